// File: rtl/cmp_serial_pkg.sv
// Shared types and constants for the byte-serial wide comparator and
// the code decoder that the ALU status stage also reuses.
package cmp_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DEC_PEND = 2'd0,
        DEC_GT   = 2'd1,
        DEC_LT   = 2'd2
    } dec_t;

    localparam int CODE_W  = 8;
    localparam int CODE_GT = 0;
    localparam int CODE_LT = 1;
    localparam int CODE_EQ = 2;

endpackage

// File: rtl/cmp_code_dec.sv
// Combinational decode of the 8-bit comparator result code. Anything that is
// not a clean one-hot in bits 2:0 with bits 7:3 clear is flagged bad and
// reported as EQ so it can never steer a magnitude decision.
module cmp_code_dec
    import cmp_serial_pkg::*;
(
    input  logic [CODE_W-1:0] cmp_code,
    output logic              is_gt,
    output logic              is_lt,
    output logic              is_eq,
    output logic              is_bad
);

    logic one_hot;
    logic hi_zero;

    always_comb begin
        one_hot = (cmp_code[2:0] == 3'b001) ||
                  (cmp_code[2:0] == 3'b010) ||
                  (cmp_code[2:0] == 3'b100);
        hi_zero = (cmp_code[7:3] == 5'b0_0000);
        is_bad  = !(one_hot && hi_zero);
        is_gt   = !is_bad && cmp_code[CODE_GT];
        is_lt   = !is_bad && cmp_code[CODE_LT];
        is_eq   = is_bad || cmp_code[CODE_EQ];
    end

endmodule

// File: rtl/cmp_serial.sv
// Byte-serial wide magnitude comparator: folds MSB-first 8-bit compare codes
// into one registered GT/LT/EQ result offered on a valid/ready handshake.
//
// state | meaning
// IDLE  | no byte of the current operation accepted yet
// RUN   | one or more bytes accepted, decision accumulating
// DONE  | result held on the outputs until res_ready
module cmp_serial
    import cmp_serial_pkg::*;
#(
    parameter  int MAX_BYTES = 8,
    localparam int CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [CODE_W-1:0] cmp_code,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_gt,
    output logic              res_lt,
    output logic              res_eq,
    output logic [CNT_W-1:0]  res_bytes,
    output logic              err_code,
    output logic              err_ovf
);

    state_t             state_q;
    state_t             state_nx;
    dec_t               dec_q;
    dec_t               dec_nx;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_inc;
    logic               err_code_q;
    logic               err_ovf_q;
    logic               res_gt_q;
    logic               res_lt_q;
    logic               res_eq_q;
    logic [CNT_W-1:0]   res_bytes_q;

    logic               code_gt;
    logic               code_lt;
    logic               code_eq;
    logic               code_bad;

    logic               xfer;
    logic               at_max;
    logic               last_xfer;
    logic               res_accept;

    cmp_code_dec u_code_dec (
        .cmp_code (cmp_code),
        .is_gt    (code_gt),
        .is_lt    (code_lt),
        .is_eq    (code_eq),
        .is_bad   (code_bad)
    );

    // count never exceeds MAX_BYTES: reaching it forces DONE, so no wrap
    assign count_inc  = count_q + CNT_W'(1);
    assign at_max     = (count_inc == CNT_W'(MAX_BYTES));
    assign xfer       = in_valid && in_ready;
    assign last_xfer  = xfer && (in_last || at_max);
    assign res_accept = res_valid && res_ready;

    always_comb begin
        dec_nx = dec_q;
        if (dec_q == DEC_PEND && !code_eq) begin
            if (code_gt) begin
                dec_nx = DEC_GT;
            end else if (code_lt) begin
                dec_nx = DEC_LT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state_q;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        case (state_q)
            IDLE, RUN: begin
                in_ready = 1'b1;
                if (xfer) begin
                    state_nx = (in_last || at_max) ? DONE : RUN;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            dec_q       <= DEC_PEND;
            err_code_q  <= 1'b0;
            err_ovf_q   <= 1'b0;
            res_gt_q    <= 1'b0;
            res_lt_q    <= 1'b0;
            res_eq_q    <= 1'b0;
            res_bytes_q <= '0;
        end else if (res_accept) begin
            count_q     <= '0;
            dec_q       <= DEC_PEND;
            err_code_q  <= 1'b0;
            err_ovf_q   <= 1'b0;
            res_gt_q    <= 1'b0;
            res_lt_q    <= 1'b0;
            res_eq_q    <= 1'b0;
            res_bytes_q <= '0;
        end else if (xfer) begin
            count_q    <= count_inc;
            dec_q      <= dec_nx;
            err_code_q <= err_code_q || code_bad;
            // result fields load once, on the closing byte, and hold through DONE
            if (last_xfer) begin
                res_gt_q    <= (dec_nx == DEC_GT);
                res_lt_q    <= (dec_nx == DEC_LT);
                res_eq_q    <= (dec_nx == DEC_PEND);
                res_bytes_q <= count_inc;
                err_ovf_q   <= !in_last;
            end
        end
    end

    assign res_gt    = res_gt_q;
    assign res_lt    = res_lt_q;
    assign res_eq    = res_eq_q;
    assign res_bytes = res_bytes_q;
    assign err_code  = err_code_q;
    assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_cmp_serial.sv
// Self-checking bench for cmp_serial: expected results are queued as each
// operation is driven and compared when the result handshake completes.
module tb_cmp_serial;

    localparam int MAXB = 8;
    localparam int CW   = $clog2(MAXB + 1);

    typedef struct packed {
        logic          gt;
        logic          lt;
        logic          eq;
        logic [CW-1:0] bytes;
        logic          ec;
        logic          eo;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_last = 1'b0;
    logic [7:0]    cmp_code = 8'h00;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic          res_gt;
    logic          res_lt;
    logic          res_eq;
    logic [CW-1:0] res_bytes;
    logic          err_code;
    logic          err_ovf;

    res_t       exp_q[$];
    res_t       exp_r;
    logic [7:0] op[16];
    int         checks = 0;
    int         failures = 0;
    time        t_prev;
    time        t_now;

    cmp_serial #(.MAX_BYTES(MAXB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .cmp_code  (cmp_code),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_gt    (res_gt),
        .res_lt    (res_lt),
        .res_eq    (res_eq),
        .res_bytes (res_bytes),
        .err_code  (err_code),
        .err_ovf   (err_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic res_t model(input int len, input bit use_last);
        res_t r;
        int   dec;
        int   n;
        bit   bad;
        bit   term;
        logic [7:0] c;
        r    = '0;
        dec  = 0;
        n    = 0;
        term = 0;
        for (int i = 0; i < len && !term; i++) begin
            c   = op[i];
            n++;
            bad = (c[7:3] != 5'd0) ||
                  !(c[2:0] == 3'b001 || c[2:0] == 3'b010 || c[2:0] == 3'b100);
            if (bad) r.ec = 1'b1;
            else if (dec == 0 && c[0]) dec = 1;
            else if (dec == 0 && c[1]) dec = 2;
            if (use_last && i == len - 1) term = 1;
            else if (n == MAXB) begin
                term = 1;
                r.eo = 1'b1;
            end
        end
        r.gt    = (dec == 1);
        r.lt    = (dec == 2);
        r.eq    = (dec == 0);
        r.bytes = CW'(n);
        return r;
    endfunction

    function automatic res_t observed();
        return {res_gt, res_lt, res_eq, res_bytes, err_code, err_ovf};
    endfunction

    // all drives happen #1 after a rising edge; returns #1 after the accepting edge
    task automatic send_byte(input logic [7:0] code, input logic last);
        int waited = 0;
        in_valid = 1'b1;
        cmp_code = code;
        in_last  = last;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 50) chk("accept_timeout", 32'(waited), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_op(input int len, input bit use_last);
        exp_q.push_back(model(len, use_last));
        for (int i = 0; i < len; i++) begin
            send_byte(op[i], use_last && (i == len - 1));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'(observed()), 32'd0);
                end else begin
                    exp_r = exp_q.pop_front();
                    chk("result", 32'(observed()), 32'(exp_r));
                end
                chk("onehot", 32'($countones({res_gt, res_lt, res_eq})), 32'd1);
            end else if (!res_valid) begin
                chk("flags_idle", 32'({res_gt, res_lt, res_eq}), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_outputs", 32'(observed()), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // EQ,EQ,GT,LT -> GT decided on byte 3
        op[0] = 8'h04; op[1] = 8'h04; op[2] = 8'h01; op[3] = 8'h02;
        run_op(4, 1);
        chk("t1_latency_valid", 32'(res_valid), 32'd1);
        chk("t1_value", 32'(observed()), 32'({1'b1, 1'b0, 1'b0, CW'(4), 1'b0, 1'b0}));
        @(posedge clk); #1;

        // EQ result held through a 5-cycle res_ready stall
        res_ready = 1'b0;
        op[0] = 8'h04; op[1] = 8'h04; op[2] = 8'h04;
        run_op(3, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t2_stall_valid", 32'(res_valid), 32'd1);
            chk("t2_stall_in_ready", 32'(in_ready), 32'd0);
            chk("t2_stall_value", 32'(observed()), 32'({1'b0, 1'b0, 1'b1, CW'(3), 1'b0, 1'b0}));
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("t2_idle_in_ready", 32'(in_ready), 32'd1);
        chk("t2_idle_valid", 32'(res_valid), 32'd0);

        // overflow at MAX_BYTES; a waiting 9th byte must stay blocked until the handshake
        res_ready = 1'b0;
        for (int i = 0; i < MAXB; i++) op[i] = 8'h04;
        run_op(MAXB, 0);
        in_valid = 1'b1;
        cmp_code = 8'h02;
        in_last  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_block_in_ready", 32'(in_ready), 32'd0);
            chk("t3_ovf_value", 32'(observed()), 32'({1'b0, 1'b0, 1'b1, CW'(MAXB), 1'b0, 1'b1}));
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        op[0] = 8'h02;
        run_op(1, 1);
        @(posedge clk); #1;

        // malformed code counts as EQ, flags err_code
        op[0] = 8'h04; op[1] = 8'h03; op[2] = 8'h02;
        run_op(3, 1);
        chk("t4_value", 32'(observed()), 32'({1'b0, 1'b1, 1'b0, CW'(3), 1'b1, 1'b0}));
        @(posedge clk); #1;

        // back-to-back single-byte operations: one result every 2 cycles
        op[0] = 8'h01;
        for (int k = 0; k < 4; k++) begin
            run_op(1, 1);
            t_now = $time;
            chk("t5_pulse_valid", 32'(res_valid), 32'd1);
            chk("t5_pulse_in_ready", 32'(in_ready), 32'd0);
            if (k > 0) chk("t5_period", 32'(t_now - t_prev), 32'd20);
            t_prev = t_now;
        end
        @(posedge clk); #1;
        chk("t5_pulse_end", 32'(res_valid), 32'd0);

        // reset mid-operation after two GT-decided bytes
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_in_ready", 32'(in_ready), 32'd1);
        chk("t6_rst_outputs", 32'({res_valid, observed()}), 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        op[0] = 8'h02;
        run_op(1, 1);
        chk("t6_value", 32'(observed()), 32'({1'b0, 1'b1, 1'b0, CW'(1), 1'b0, 1'b0}));
        @(posedge clk); #1;

        // randomised operations, lengths within MAX_BYTES
        for (int n = 0; n < 8; n++) begin
            int len;
            bit use_last;
            len      = $urandom_range(1, MAXB);
            use_last = ($urandom_range(0, 3) != 0);
            if (!use_last) len = MAXB;
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 4))
                    0:       op[i] = 8'h01;
                    1:       op[i] = 8'h02;
                    4:       op[i] = 8'($urandom_range(0, 255));
                    default: op[i] = 8'h04;
                endcase
            end
            run_op(len, use_last);
            @(posedge clk); #1;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmp_serial.md
Name: cmp_serial

Overview:
- Byte-serial wide magnitude comparator, directly downstream of the 8-bit comparator.
- Consumes that comparator's 8-bit result code, one operand byte-pair per transfer, most significant byte first.
- Accumulates an unsigned A-vs-B decision for operands up to MAX_BYTES bytes wide.
- Presents the final GT/LT/EQ result through a valid/ready handshake to the ALU status stage.

Parameters:
- MAX_BYTES, 8, maximum operand length in bytes; legal range 1..255.
- CNT_W, $clog2(MAX_BYTES+1), width of the byte counter and of res_bytes; derived, not overridden.

Ports:
- clk  input  1  single clock; all flops rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  cmp_code and in_last are valid this cycle.
- in_ready  output  1  block accepts a byte this cycle; a transfer occurs when in_valid && in_ready.
- in_last  input  1  current byte-pair is the least significant one.
- cmp_code  input  8  comparator code: bit0 GT, bit1 LT, bit2 EQ, bits7:3 must be 0.
- res_valid  output  1  result held stable until accepted.
- res_ready  input  1  consumer accepts the result.
- res_gt  output  1  wide A > B.
- res_lt  output  1  wide A < B.
- res_eq  output  1  wide A == B.
- res_bytes  output  CNT_W  number of byte-pairs consumed.
- err_code  output  1  at least one malformed code was seen in this operation.
- err_ovf  output  1  operation was terminated at MAX_BYTES without in_last.

Behaviour:
- Reset (async assert, sync-released flops):
  - state IDLE, count 0, decision EQ-pending.
  - res_valid, res_gt, res_lt, res_eq, res_bytes, err_code and err_ovf all 0.
  - in_ready = 1, decoded from state IDLE.
- States:
  - IDLE: no byte accepted yet; in_ready = 1.
  - RUN: 1 or more bytes accepted; in_ready = 1.
  - DONE: in_ready = 0, res_valid = 1.
- Transitions:
  - IDLE/RUN, on transfer with in_last=0 and count+1 < MAX_BYTES -> RUN.
  - IDLE/RUN, on transfer with in_last=1 -> DONE.
  - IDLE/RUN, on transfer where count+1 == MAX_BYTES and in_last=0 -> DONE, err_ovf=1.
  - DONE, on res_ready=1 -> IDLE next cycle; count, decision and error flags are cleared.
- No bypass: a byte cannot be accepted in the same cycle a result is accepted.
- Decision rule, evaluated on each transfer:
  - If the decision is still pending and the code is GT, the decision becomes GT.
  - If the decision is still pending and the code is LT, the decision becomes LT.
  - Once GT or LT is decided, later bytes are consumed and counted but ignored.
  - If the decision is still pending at the end, the result is EQ.
- Malformed code: bits2:0 not exactly one-hot, or bits7:3 nonzero.
  - Sets err_code (sticky for the operation).
  - Treated as EQ for the decision.
- Result outputs:
  - Exactly one of res_gt/res_lt/res_eq is 1 whenever res_valid = 1; all are 0 otherwise.
  - Result fields are registered and stable throughout DONE.
- Latency: res_valid rises the cycle after the last transfer; minimum operation is 1 transfer plus 1 cycle.
- Throughput: one byte per cycle in IDLE/RUN; one result at most every N+1 cycles for N bytes, plus any res_ready stall.
- Counter: saturates by construction at MAX_BYTES; no wrap.
- in_valid=0 in RUN: state holds indefinitely; no timeout.
- Reset mid-operation (any state): the operation is abandoned and the reset values above apply immediately.
- MAX_BYTES=1: every transfer goes to DONE; err_ovf is set only if in_last=0.

Decomposition:
- Package cmp_serial_pkg holds:
  - state enum {IDLE, RUN, DONE}.
  - decision enum {DEC_PEND, DEC_GT, DEC_LT}.
  - code bit-index constants CODE_GT=0, CODE_LT=1, CODE_EQ=2.
- Sub-module cmp_code_dec: purely combinational.
  - Maps cmp_code to is_gt/is_lt/is_eq/is_bad.
  - Enforces the malformed-code rule; reused by the ALU status stage.
- The FSM, counter and result registers live in cmp_serial.

Test Plan:
- 4 bytes with codes EQ,EQ,GT,LT (0x04,0x04,0x01,0x02), last on byte 4 -> next cycle res_valid=1, res_gt=1, res_bytes=4, err_code=0, err_ovf=0.
- 3 bytes, all 0x04, last on byte 3, res_ready held 0 for 5 cycles -> res_eq=1, res_bytes=3, outputs stable and in_ready=0 for all 5 cycles; IDLE the cycle after res_ready=1.
- MAX_BYTES=8, 8 bytes of 0x04 then 0x02 never asserting in_last -> DONE after byte 8, err_ovf=1, res_eq=1, res_bytes=8; the 9th byte is not accepted until after the result handshake.
- Codes 0x04, 0x03 (bad), 0x02, last -> err_code=1, res_lt=1, res_bytes=3.
- Single byte 0x01 with in_last=1 and res_ready=1 permanently -> res_valid pulses 1 cycle, in_ready low for exactly that cycle; back-to-back operations give one result every 2 cycles.
- rst_n pulled low in RUN after 2 GT-decided bytes, then released and 1 byte 0x02 sent with last -> no stale result; res_lt=1, res_bytes=1.
